pll_reset_ctrl: RTL and testbench
=================================

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 The block SHALL have one clock, refclk, and a synchronous, active-high reset, rst; all state SHALL change only on the rising edge of refclk.
REQ-002 Parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset attempt.
REQ-003 Parameter LOCK_TIMEOUT, default 50000: maximum cycles to wait for lock per attempt (1 ms at 50 MHz).
REQ-004 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before releasing system reset.
REQ-005 Parameter LOSS_FILTER, default 4: consecutive synchronized-unlock cycles in RUN that count as a lock loss.
REQ-006 Parameter MAX_RETRIES, default 3, legal range 0..15: PLL re-reset attempts before FAULT.
REQ-007 refclk  in  1  free-running 50 MHz reference; the same clock that feeds the PLL.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 locked  in  1  PLL lock indicator; asynchronous to refclk.
REQ-010 pll_rst  out  1  reset to the PLL; active high.
REQ-011 sys_rst  out  1  system reset to the CPU clock domain; active high.
REQ-012 ready  out  1  high only in RUN.
REQ-013 fault  out  1  sticky; high only in FAULT.
REQ-014 retry_cnt  out  4  PLL reset attempts made since the last entry into RUN or the last rst.
REQ-015 lock_loss_cnt  out  8  lock losses detected in RUN; saturates at 255.

Function
REQ-016 locked SHALL pass through a 2-flop synchronizer; its output, locked_s, SHALL be the only form of locked used by the FSM.
REQ-017 All outputs SHALL be registered and SHALL update on the same edge as the state transition that sets them.
REQ-018 The FSM SHALL have five states: PLL_RST, WAIT_LOCK, STABLE, RUN and FAULT.
REQ-019 Outputs per state SHALL be: pll_rst=1 in PLL_RST and FAULT, otherwise 0; sys_rst=0 only in RUN; ready=1 only in RUN; fault=1 only in FAULT.
REQ-020 PLL_RST SHALL hold for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the cycle counter cleared.
REQ-021 WAIT_LOCK SHALL go to STABLE, counter cleared, on the first cycle locked_s=1; otherwise it SHALL increment the counter.
REQ-022 WAIT_LOCK timeout, at counter = LOCK_TIMEOUT-1 with locked_s=0: if retry_cnt = MAX_RETRIES go to FAULT; else increment retry_cnt and go to PLL_RST.
REQ-023 STABLE SHALL return to WAIT_LOCK on locked_s=0, clearing the counter and leaving retry_cnt unchanged.
REQ-024 STABLE SHALL go to RUN after locked_s has been 1 for LOCK_STABLE_CYCLES consecutive cycles.
REQ-025 On entry to RUN, retry_cnt SHALL clear to 0.
REQ-026 RUN SHALL count consecutive locked_s=0 cycles and clear that count when locked_s=1, so glitches shorter than LOSS_FILTER cycles are ignored and ready stays high.
REQ-027 When the unlock count reaches LOSS_FILTER, the FSM SHALL go to PLL_RST on that edge, asserting sys_rst and pll_rst and incrementing lock_loss_cnt (saturating at 255).
REQ-028 FAULT SHALL be terminal; only rst exits it.
REQ-029 Counters SHALL be sized by $clog2 of the largest relevant parameter, and SHALL neither wrap nor overflow within any state.
REQ-030 If locked is held at 1 from rst release, sys_rst SHALL deassert exactly PLL_RST_CYCLES + 1 + LOCK_STABLE_CYCLES edges after the first edge that samples rst=0 (1041 with defaults).

Reset
REQ-031 rst=1 SHALL have priority over every other event, including mid-operation, and SHALL set: state=PLL_RST, counters=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0.
REQ-032 rst asserted while in RUN SHALL raise sys_rst on the first edge that samples rst=1.

Verification
REQ-033 Nominal: defaults, locked=1 throughout -> pll_rst high for 16 cycles; sys_rst falls and ready rises at edge 1041; retry_cnt=0.
REQ-034 Glitch: in RUN, locked=0 for 3 cycles -> ready stays 1, sys_rst stays 0, lock_loss_cnt unchanged.
REQ-035 Loss: in RUN, locked=0 for 10 cycles -> sys_rst=1 and pll_rst=1 within 2+4 cycles of the drop, lock_loss_cnt=1, full sequence re-runs once locked returns.
REQ-036 Timeout/fault: LOCK_TIMEOUT=100, locked=0 forever -> 4 pll_rst pulses, retry_cnt reaches 3, then fault=1 with pll_rst=1 held; rst clears to the reset values.
REQ-037 Stability restart: in STABLE at count 500, locked=0 for 1 cycle -> back to WAIT_LOCK, a full 1024-cycle stability window is required again, retry_cnt unchanged.
REQ-038 Saturation: force 260 lock losses -> lock_loss_cnt=255.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// PLL bring-up and system reset sequencer: resets the PLL, waits for a stable lock,
// releases the system reset, and re-runs the sequence on a filtered lock loss.
module pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER        = 4,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared counter; each state only counts up to its own limit minus one.
    localparam int CNT_MAX = max_i(max_i(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                   max_i(LOCK_STABLE_CYCLES, LOSS_FILTER));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_nxt;
    logic [7:0]       r_loss;
    logic [7:0]       w_loss_nxt;

    logic             r_sync1;
    logic             r_locked_s;

    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             r_fault;
    logic             w_pll_rst_nxt;
    logic             w_sys_rst_nxt;
    logic             w_ready_nxt;
    logic             w_fault_nxt;

    // locked comes from the PLL's own lock detector, unrelated to refclk phase.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= locked;
            r_locked_s <= r_sync1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_PLL_RST;
            r_cnt     <= '0;
            r_retry   <= 4'd0;
            r_loss    <= 8'd0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_sys_rst <= w_sys_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == PLL_RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retry == RETRY_LIMIT) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt = S_PLL_RST;
                        w_retry_nxt = r_retry + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STABLE: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Counter holds the run of consecutive unlocked cycles.
                if (r_locked_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LOSS_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                    if (r_loss != 8'hFF) begin
                        w_loss_nxt = r_loss + 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Decoded from the next state so outputs flip on the transition edge itself.
    always_comb begin
        w_pll_rst_nxt = (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAULT);
        w_sys_rst_nxt = (w_state_nxt != S_RUN);
        w_ready_nxt   = (w_state_nxt == S_RUN);
        w_fault_nxt   = (w_state_nxt == S_FAULT);
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst       = r_sys_rst;
    assign ready         = r_ready;
    assign fault         = r_fault;
    assign retry_cnt     = r_retry;
    assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: expected values are queued as stimulus is applied
// and popped against DUT outputs sampled 1 ns after the rising edge.
module tb_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b1;
    logic       pll_rst, sys_rst, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    logic       s_locked = 1'b1;
    logic       s_pll_rst, s_sys_rst, s_ready, s_fault;
    logic [3:0] s_retry_cnt;
    logic [7:0] s_lock_loss_cnt;

    always #5 refclk = ~refclk;

    pll_reset_ctrl #(
        .PLL_RST_CYCLES(16), .LOCK_TIMEOUT(100), .LOCK_STABLE_CYCLES(1024),
        .LOSS_FILTER(4), .MAX_RETRIES(3)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    // Short-sequence instance so hundreds of lock losses fit in a short run.
    pll_reset_ctrl #(
        .PLL_RST_CYCLES(2), .LOCK_TIMEOUT(100), .LOCK_STABLE_CYCLES(4),
        .LOSS_FILTER(2), .MAX_RETRIES(3)
    ) u_sat (
        .refclk(refclk), .rst(rst), .locked(s_locked),
        .pll_rst(s_pll_rst), .sys_rst(s_sys_rst), .ready(s_ready), .fault(s_fault),
        .retry_cnt(s_retry_cnt), .lock_loss_cnt(s_lock_loss_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad_ready, bad_sys;
        logic prev;
        int   falls;
        logic [3:0] r116;
        logic [7:0] loss100, loss255;

        // ---- reset values ----
        tick(3);
        expect_v("rst_pll_rst", 1);  check_v(32'(pll_rst));
        expect_v("rst_sys_rst", 1);  check_v(32'(sys_rst));
        expect_v("rst_ready", 0);    check_v(32'(ready));
        expect_v("rst_fault", 0);    check_v(32'(fault));
        expect_v("rst_retry", 0);    check_v(32'(retry_cnt));
        expect_v("rst_loss", 0);     check_v(32'(lock_loss_cnt));

        // ---- nominal bring-up, locked high throughout ----
        rst = 1'b0;
        tick(15);
        expect_v("nom_pll_rst_e15", 1);  check_v(32'(pll_rst));
        tick(1);
        expect_v("nom_pll_rst_e16", 0);  check_v(32'(pll_rst));
        expect_v("nom_sys_rst_e16", 1);  check_v(32'(sys_rst));
        tick(1024);
        expect_v("nom_sys_rst_e1040", 1); check_v(32'(sys_rst));
        expect_v("nom_ready_e1040", 0);   check_v(32'(ready));
        tick(1);
        expect_v("nom_sys_rst_e1041", 0); check_v(32'(sys_rst));
        expect_v("nom_ready_e1041", 1);   check_v(32'(ready));
        expect_v("nom_retry", 0);         check_v(32'(retry_cnt));

        // ---- 3-cycle glitch in RUN is filtered ----
        bad_ready = 1'b0;
        bad_sys   = 1'b0;
        locked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) locked = 1'b1;
            tick(1);
            if (!ready) bad_ready = 1'b1;
            if (sys_rst) bad_sys = 1'b1;
        end
        expect_v("glitch_ready_dropped", 0); check_v(32'(bad_ready));
        expect_v("glitch_sys_rst_rose", 0);  check_v(32'(bad_sys));
        expect_v("glitch_loss", 0);          check_v(32'(lock_loss_cnt));

        // ---- 10-cycle loss in RUN ----
        locked = 1'b0;
        tick(5);
        expect_v("loss_ready_d5", 1);   check_v(32'(ready));
        tick(1);
        expect_v("loss_sys_rst_d6", 1); check_v(32'(sys_rst));
        expect_v("loss_pll_rst_d6", 1); check_v(32'(pll_rst));
        expect_v("loss_ready_d6", 0);   check_v(32'(ready));
        expect_v("loss_cnt_d6", 1);     check_v(32'(lock_loss_cnt));
        tick(4);
        locked = 1'b1;
        tick(1036);
        expect_v("loss_ready_d1046", 0); check_v(32'(ready));
        tick(1);
        expect_v("loss_ready_d1047", 1); check_v(32'(ready));
        expect_v("loss_cnt_after", 1);   check_v(32'(lock_loss_cnt));
        expect_v("loss_retry", 0);       check_v(32'(retry_cnt));

        // ---- rst while in RUN ----
        rst = 1'b1;
        tick(1);
        expect_v("rstrun_sys_rst", 1); check_v(32'(sys_rst));
        expect_v("rstrun_pll_rst", 1); check_v(32'(pll_rst));
        expect_v("rstrun_ready", 0);   check_v(32'(ready));
        expect_v("rstrun_loss", 0);    check_v(32'(lock_loss_cnt));

        // ---- one-cycle drop at stability count ~500 restarts the window ----
        rst = 1'b0;
        tick(517);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        expect_v("stab_sys_rst_e520", 1); check_v(32'(sys_rst));
        expect_v("stab_retry_e520", 0);   check_v(32'(retry_cnt));
        tick(521);
        expect_v("stab_ready_e1041", 0);  check_v(32'(ready));
        tick(503);
        expect_v("stab_ready_e1544", 0);  check_v(32'(ready));
        tick(1);
        expect_v("stab_ready_e1545", 1);  check_v(32'(ready));
        expect_v("stab_retry_e1545", 0);  check_v(32'(retry_cnt));

        // ---- lock never arrives: retries then FAULT ----
        rst = 1'b1;
        locked = 1'b0;
        tick(2);
        rst = 1'b0;
        falls = 0;
        r116 = 4'd0;
        prev = pll_rst;
        for (int i = 1; i <= 463; i++) begin
            tick(1);
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
            if (i == 116) r116 = retry_cnt;
        end
        expect_v("to_pll_rst_falls", 4); check_v(32'(falls));
        expect_v("to_retry_e116", 1);    check_v(32'(r116));
        expect_v("to_retry_e463", 3);    check_v(32'(retry_cnt));
        expect_v("to_fault_e463", 0);    check_v(32'(fault));
        tick(1);
        expect_v("to_fault_e464", 1);    check_v(32'(fault));
        expect_v("to_pll_rst_e464", 1);  check_v(32'(pll_rst));
        expect_v("to_sys_rst_e464", 1);  check_v(32'(sys_rst));
        tick(200);
        locked = 1'b1;
        tick(20);
        expect_v("to_fault_sticky", 1);   check_v(32'(fault));
        expect_v("to_pll_rst_held", 1);   check_v(32'(pll_rst));
        expect_v("to_ready_held", 0);     check_v(32'(ready));
        rst = 1'b1;
        tick(1);
        expect_v("to_rst_fault", 0);   check_v(32'(fault));
        expect_v("to_rst_retry", 0);   check_v(32'(retry_cnt));
        expect_v("to_rst_pll_rst", 1); check_v(32'(pll_rst));
        expect_v("to_rst_sys_rst", 1); check_v(32'(sys_rst));
        expect_v("to_rst_ready", 0);   check_v(32'(ready));

        // ---- 260 lock losses on the short instance: counter saturates ----
        rst = 1'b0;
        loss100 = 8'd0;
        loss255 = 8'd0;
        for (int n = 0; n < 260; n++) begin
            for (int k = 0; k < 100 && !s_ready; k++) tick(1);
            s_locked = 1'b0;
            for (int k = 0; k < 20 && s_ready; k++) tick(1);
            s_locked = 1'b1;
            if (n == 99)  loss100 = s_lock_loss_cnt;
            if (n == 254) loss255 = s_lock_loss_cnt;
        end
        expect_v("sat_loss_100", 100); check_v(32'(loss100));
        expect_v("sat_loss_255", 255); check_v(32'(loss255));
        expect_v("sat_loss_260", 255); check_v(32'(s_lock_loss_cnt));
        for (int k = 0; k < 100 && !s_ready; k++) tick(1);
        expect_v("sat_ready", 1);   check_v(32'(s_ready));
        expect_v("sat_sys_rst", 0); check_v(32'(s_sys_rst));
        expect_v("sat_pll_rst", 0); check_v(32'(s_pll_rst));
        expect_v("sat_fault", 0);   check_v(32'(s_fault));
        expect_v("sat_retry", 0);   check_v(32'(s_retry_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
